// File: rtl/alu_operand_stage.sv
// Execute-stage ALU operand register: operand select, M/W forwarding, valid/ready capture.
// Define ALU_OPSTAGE_SKID_EN to add a second (skid) entry with a registered DReady.
module alu_operand_stage #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned CTRLW = 12
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             DValid,
   output logic             DReady,
   input  logic [4:0]       Rs1D,
   input  logic [4:0]       Rs2D,
   input  logic [WIDTH-1:0] R1D,
   input  logic [WIDTH-1:0] R2D,
   input  logic [WIDTH-1:0] PCD,
   input  logic [WIDTH-1:0] ImmD,
   input  logic             ASrcD,
   input  logic             BSrcD,
   input  logic [CTRLW-1:0] CtrlD,
   input  logic [4:0]       RdM,
   input  logic             RegWriteM,
   input  logic [WIDTH-1:0] ResultM,
   input  logic [4:0]       RdW,
   input  logic             RegWriteW,
   input  logic [WIDTH-1:0] ResultW,
   input  logic             FlushE,
   output logic             EValid,
   input  logic             EReady,
   output logic [WIDTH-1:0] AE,
   output logic [WIDTH-1:0] BE,
   output logic [CTRLW-1:0] CtrlE,
   output logic [1:0]       FwdAE,
   output logic [1:0]       FwdBE
);

   typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

   typedef struct packed {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [CTRLW-1:0] ctrl;
      logic [1:0]       fwd_a;
      logic [1:0]       fwd_b;
   } entry_t;

   state_e state_q;
   entry_t out_q;
   entry_t incoming;
   logic [1:0] fwd_a, fwd_b;
   logic [WIDTH-1:0] rs1_val, rs2_val;
   logic accept, consume;

   // M beats W; x0 is hard-wired and never forwarded.
   function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic [4:0] rd_m,
                                          input logic wr_m, input logic [4:0] rd_w,
                                          input logic wr_w);
      if (rs == 5'd0) return 2'b00;
      if (wr_m && rd_m == rs) return 2'b10;
      if (wr_w && rd_w == rs) return 2'b01;
      return 2'b00;
   endfunction

   always_comb begin
      fwd_a = fwd_sel(Rs1D, RdM, RegWriteM, RdW, RegWriteW);
      fwd_b = fwd_sel(Rs2D, RdM, RegWriteM, RdW, RegWriteW);
      case (fwd_a)
         2'b10:   rs1_val = ResultM;
         2'b01:   rs1_val = ResultW;
         default: rs1_val = R1D;
      endcase
      case (fwd_b)
         2'b10:   rs2_val = ResultM;
         2'b01:   rs2_val = ResultW;
         default: rs2_val = R2D;
      endcase
      incoming.a     = ASrcD ? PCD : rs1_val;
      incoming.b     = BSrcD ? ImmD : rs2_val;
      incoming.ctrl  = CtrlD;
      incoming.fwd_a = ASrcD ? 2'b00 : fwd_a;
      incoming.fwd_b = BSrcD ? 2'b00 : fwd_b;
   end

   assign EValid  = (state_q != StEmpty);
   assign accept  = DValid & DReady;
   assign consume = EValid & EReady;

   assign AE    = out_q.a;
   assign BE    = out_q.b;
   assign CtrlE = out_q.ctrl;
   assign FwdAE = out_q.fwd_a;
   assign FwdBE = out_q.fwd_b;

`ifdef ALU_OPSTAGE_SKID_EN
   entry_t skid_q;
   logic   dready_q;

   assign DReady = reset & dready_q;
`else
   // Single entry: a stall propagates straight back to decode.
   assign DReady = reset & (~EValid | EReady);
`endif

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= StEmpty;
         out_q    <= '0;
`ifdef ALU_OPSTAGE_SKID_EN
         skid_q   <= '0;
         dready_q <= 1'b0;
`endif
      end else if (FlushE) begin
         state_q  <= StEmpty;
`ifdef ALU_OPSTAGE_SKID_EN
         dready_q <= 1'b1;
`endif
      end else begin
`ifdef ALU_OPSTAGE_SKID_EN
         dready_q <= 1'b1;
`endif
         case (state_q)
            StEmpty: begin
               if (accept) begin
                  out_q   <= incoming;
                  state_q <= StOne;
               end
            end
            StOne: begin
               if (accept && consume) begin
                  out_q <= incoming;
`ifdef ALU_OPSTAGE_SKID_EN
               end else if (accept) begin
                  skid_q   <= incoming;
                  state_q  <= StTwo;
                  dready_q <= 1'b0;
`endif
               end else if (consume) begin
                  state_q <= StEmpty;
               end
            end
`ifdef ALU_OPSTAGE_SKID_EN
            StTwo: begin
               if (consume) begin
                  out_q   <= skid_q;
                  state_q <= StOne;
               end else begin
                  dready_q <= 1'b0;
               end
            end
`endif
            default: state_q <= StEmpty;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Bench for alu_operand_stage: directed vector table, multi-cycle corner sequences and
// randomized traffic against a queue-based reference model.
module tb_alu_operand_stage;
   localparam int unsigned W = 64;
   localparam int unsigned C = 12;
`ifdef ALU_OPSTAGE_SKID_EN
   localparam bit SKID = 1'b1;
`else
   localparam bit SKID = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset, dvalid, dready, asrc, bsrc, rwm, rww, flush, evalid, eready;
   logic [4:0] rs1, rs2, rdm, rdw;
   logic [W-1:0] r1, r2, pc, imm, resm, resw, ae, be;
   logic [C-1:0] ctrl, ctrle;
   logic [1:0] fwdae, fwdbe;

   always #5 clk = ~clk;

   alu_operand_stage #(.WIDTH(W), .CTRLW(C)) dut (
      .clk(clk), .reset(reset), .DValid(dvalid), .DReady(dready),
      .Rs1D(rs1), .Rs2D(rs2), .R1D(r1), .R2D(r2), .PCD(pc), .ImmD(imm),
      .ASrcD(asrc), .BSrcD(bsrc), .CtrlD(ctrl),
      .RdM(rdm), .RegWriteM(rwm), .ResultM(resm),
      .RdW(rdw), .RegWriteW(rww), .ResultW(resw),
      .FlushE(flush), .EValid(evalid), .EReady(eready),
      .AE(ae), .BE(be), .CtrlE(ctrle), .FwdAE(fwdae), .FwdBE(fwdbe)
   );

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [C-1:0] ctrl;
      logic [1:0]   fa;
      logic [1:0]   fb;
   } entry_t;

   typedef struct {
      logic [4:0] rs1; logic [4:0] rs2;
      logic [W-1:0] r1; logic [W-1:0] r2; logic [W-1:0] pc; logic [W-1:0] imm;
      logic asrc; logic bsrc; logic [C-1:0] ctrl;
      logic [4:0] rdm; logic rwm; logic [W-1:0] resm;
      logic [4:0] rdw; logic rww; logic [W-1:0] resw;
      logic [W-1:0] exp_a; logic [W-1:0] exp_b; logic [1:0] exp_fa; logic [1:0] exp_fb;
   } vec_t;

   entry_t q[$];
   logic [W-1:0] consumed[$];
   bit dr_reg = 1'b0;
   bit last_acc;
   int checks = 0;
   int passes = 0;
   int dready_low = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic void resolve(input logic [4:0] rs, input logic [W-1:0] rf,
                                   output logic [W-1:0] v, output logic [1:0] f);
      if (rs != 0 && rwm && rdm == rs) begin
         v = resm; f = 2'b10;
      end else if (rs != 0 && rww && rdw == rs) begin
         v = resw; f = 2'b01;
      end else begin
         v = rf; f = 2'b00;
      end
   endfunction

   function automatic entry_t ref_entry();
      entry_t e;
      logic [W-1:0] v1, v2;
      logic [1:0] f1, f2;
      resolve(rs1, r1, v1, f1);
      resolve(rs2, r2, v2, f2);
      e.a = asrc ? pc : v1;
      e.fa = asrc ? 2'b00 : f1;
      e.b = bsrc ? imm : v2;
      e.fb = bsrc ? 2'b00 : f2;
      e.ctrl = ctrl;
      return e;
   endfunction

   function automatic bit model_dready();
      if (!reset) return 1'b0;
      if (SKID) return dr_reg;
      return (q.size() == 0) || eready;
   endfunction

   // One clock: check pre-edge DReady, advance the model, check registered outputs.
   task automatic tick();
      entry_t e;
      bit exp_dr, acc, con;
      #1;
      exp_dr = model_dready();
      chk("dready_pre", 64'(dready), 64'(exp_dr));
      if (dready !== 1'b1) dready_low++;
      acc = dvalid && exp_dr;
      con = (q.size() > 0) && eready;
      if (con) consumed.push_back(ae);
      e = ref_entry();
      last_acc = acc && reset && !flush;
      @(posedge clk);
      if (!reset || flush) begin
         q.delete();
      end else begin
         if (con) q.delete(0);
         if (acc) q.push_back(e);
      end
      dr_reg = !reset ? 1'b0 : (flush ? 1'b1 : (q.size() < 2));
      #1;
      chk("evalid", 64'(evalid), 64'(q.size() > 0));
      chk("dready_post", 64'(dready), 64'(model_dready()));
      if (q.size() > 0) begin
         chk("ae", 64'(ae), 64'(q[0].a));
         chk("be", 64'(be), 64'(q[0].b));
         chk("ctrle", 64'(ctrle), 64'(q[0].ctrl));
         chk("fwdae", 64'(fwdae), 64'(q[0].fa));
         chk("fwdbe", 64'(fwdbe), 64'(q[0].fb));
      end
   endtask

   task automatic idle_inputs();
      dvalid = 0; rs1 = 0; rs2 = 0; r1 = 0; r2 = 0; pc = 0; imm = 0; asrc = 0; bsrc = 0;
      ctrl = 0; rdm = 0; rwm = 0; resm = 0; rdw = 0; rww = 0; resw = 0; flush = 0;
      eready = 1;
   endtask

   vec_t vecs[6];

   initial begin
      vecs[0] = '{5'd5, 5'd7, 64'h1, 64'h1234, 64'h0, 64'h0, 1'b0, 1'b0, 12'h0a1,
                  5'd5, 1'b1, 64'hAA, 5'd5, 1'b1, 64'hBB, 64'hAA, 64'h1234, 2'b10, 2'b00};
      vecs[1] = '{5'd3, 5'd4, 64'h99, 64'h98, 64'h0, 64'h0, 1'b0, 1'b0, 12'h5c3,
                  5'd4, 1'b1, 64'h11, 5'd3, 1'b1, 64'h22, 64'h22, 64'h11, 2'b01, 2'b10};
      vecs[2] = '{5'd0, 5'd0, 64'h0, 64'h0, 64'h0, 64'h0, 1'b0, 1'b0, 12'hfff,
                  5'd0, 1'b1, 64'hFF, 5'd0, 1'b1, 64'hEE, 64'h0, 64'h0, 2'b00, 2'b00};
      vecs[3] = '{5'd0, 5'd0, 64'h0, 64'h0, 64'h400, 64'h10, 1'b1, 1'b1, 12'h001,
                  5'd0, 1'b1, 64'hFF, 5'd0, 1'b0, 64'h0, 64'h400, 64'h10, 2'b00, 2'b00};
      vecs[4] = '{5'd6, 5'd6, 64'h3, 64'h4, 64'h800, 64'h0, 1'b1, 1'b0, 12'h800,
                  5'd6, 1'b1, 64'h55, 5'd6, 1'b1, 64'h66, 64'h800, 64'h55, 2'b00, 2'b10};
      vecs[5] = '{5'd8, 5'd9, 64'h77, 64'h5, 64'h0, {W{1'b1}}, 1'b0, 1'b1, 12'h3c3,
                  5'd8, 1'b0, 64'h1, 5'd8, 1'b0, 64'h2, 64'h77, {W{1'b1}}, 2'b00, 2'b00};

      idle_inputs();
      reset = 0;
      tick();
      tick();
      chk("rst_ae", 64'(ae), 64'h0);
      chk("rst_be", 64'(be), 64'h0);
      chk("rst_ctrle", 64'(ctrle), 64'h0);
      chk("rst_fwd", 64'({fwdae, fwdbe}), 64'h0);
      chk("rst_dready", 64'(dready), 64'h0);
      reset = 1;
      tick();
      chk("release_dready", 64'(dready), 64'h1);

      // Directed operand/forwarding vectors from an empty stage.
      for (int i = 0; i < 6; i++) begin
         rs1 = vecs[i].rs1; rs2 = vecs[i].rs2; r1 = vecs[i].r1; r2 = vecs[i].r2;
         pc = vecs[i].pc; imm = vecs[i].imm; asrc = vecs[i].asrc; bsrc = vecs[i].bsrc;
         ctrl = vecs[i].ctrl; rdm = vecs[i].rdm; rwm = vecs[i].rwm; resm = vecs[i].resm;
         rdw = vecs[i].rdw; rww = vecs[i].rww; resw = vecs[i].resw;
         dvalid = 1; eready = 1;
         tick();
         chk($sformatf("vec%0d_evalid", i), 64'(evalid), 64'h1);
         chk($sformatf("vec%0d_ae", i), 64'(ae), 64'(vecs[i].exp_a));
         chk($sformatf("vec%0d_be", i), 64'(be), 64'(vecs[i].exp_b));
         chk($sformatf("vec%0d_ctrl", i), 64'(ctrle), 64'(vecs[i].ctrl));
         chk($sformatf("vec%0d_fwda", i), 64'(fwdae), 64'(vecs[i].exp_fa));
         chk($sformatf("vec%0d_fwdb", i), 64'(fwdbe), 64'(vecs[i].exp_fb));
         // Later M/W activity must not disturb the held entry.
         dvalid = 0; eready = 0; resm = 64'hDEAD; resw = 64'hBEEF;
         tick();
         chk($sformatf("vec%0d_frozen", i), 64'(ae), 64'(vecs[i].exp_a));
         eready = 1;
         tick();
      end

      // Back-to-back I0..I2 with a single-cycle EReady drop.
      begin
         bit pat[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
         int k = 0;
         idle_inputs();
         consumed.delete();
         dready_low = 0;
         for (int c = 0; c < 12 && consumed.size() < 3; c++) begin
            eready = (c < 6) ? pat[c] : 1'b1;
            asrc = 1;
            dvalid = (k < 3);
            pc = W'(k + 1);
            tick();
            if (last_acc) k++;
         end
         chk("seq_count", 64'(consumed.size()), 64'd3);
         for (int i = 0; i < 3; i++)
            chk($sformatf("seq_ae%0d", i), (i < consumed.size()) ? 64'(consumed[i]) : 64'hx,
                64'(i + 1));
         chk("seq_dready_low", 64'(dready_low), 64'd1);
      end

      // Flush with a concurrent accept.
      idle_inputs();
      asrc = 1; pc = 64'h11; dvalid = 1; eready = 0;
      tick();
      flush = 1; pc = 64'h77; eready = 1;
      tick();
      chk("flush_evalid", 64'(evalid), 64'h0);
      chk("flush_dready", 64'(dready), 64'h1);
      flush = 0; dvalid = 0;
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("flush_gone", 64'(evalid), 64'h0);
      end

      // Reset mid-stream with the stage full.
      asrc = 1; bsrc = 1; imm = 64'h5; dvalid = 1; eready = 0; pc = 64'h21;
      tick();
      pc = 64'h22;
      tick();
      chk("full_evalid", 64'(evalid), 64'h1);
      reset = 0;
      tick();
      chk("mrst_evalid", 64'(evalid), 64'h0);
      chk("mrst_ae", 64'(ae), 64'h0);
      chk("mrst_be", 64'(be), 64'h0);
      chk("mrst_dready", 64'(dready), 64'h0);
      reset = 1; dvalid = 0;
      tick();
      chk("mrst_release", 64'(dready), 64'h1);

      // Randomized traffic against the model.
      for (int n = 0; n < 400; n++) begin
         rs1 = 5'($urandom_range(0, 3)); rs2 = 5'($urandom_range(0, 3));
         rdm = 5'($urandom_range(0, 3)); rdw = 5'($urandom_range(0, 3));
         rwm = 1'($urandom_range(0, 1)); rww = 1'($urandom_range(0, 1));
         r1 = {$urandom, $urandom}; r2 = {$urandom, $urandom};
         pc = {$urandom, $urandom}; imm = {$urandom, $urandom};
         resm = {$urandom, $urandom}; resw = {$urandom, $urandom};
         asrc = 1'($urandom_range(0, 1)); bsrc = 1'($urandom_range(0, 1));
         ctrl = C'($urandom);
         dvalid = ($urandom_range(0, 3) != 0);
         eready = ($urandom_range(0, 3) != 0);
         flush = ($urandom_range(0, 15) == 0);
         reset = ($urandom_range(0, 63) != 0);
         tick();
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
